pipe_mips20: RTL and testbench

//  Five-stage in-order 32-bit MIPS-style core: IF, ID, EX, MEM, WB.

---
 rtl/pipe_mips20.sv | 223 ++++++++++++++++++++++
 tb/tb_pipe_mips20.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mips20.sv
// Five-stage in-order MIPS-style core with unified word memory, 32x32 register file
// and a multi-cycle square-and-multiply POW instruction held in EX.
module pipe_mips20 #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_result,
    output logic            halted_out,
    output logic [XLEN-1:0] debug_operand1,
    output logic [XLEN-1:0] debug_operand2
);
    localparam int unsigned AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OpAdd   = 6'h00;
    localparam logic [5:0] OpSub   = 6'h01;
    localparam logic [5:0] OpAnd   = 6'h02;
    localparam logic [5:0] OpOr    = 6'h03;
    localparam logic [5:0] OpSlt   = 6'h04;
    localparam logic [5:0] OpMul   = 6'h05;
    localparam logic [5:0] OpPow   = 6'h10;
    localparam logic [5:0] OpLw    = 6'h08;
    localparam logic [5:0] OpSw    = 6'h09;
    localparam logic [5:0] OpAddi  = 6'h0A;
    localparam logic [5:0] OpSubi  = 6'h0B;
    localparam logic [5:0] OpSlti  = 6'h0C;
    localparam logic [5:0] OpBneqz = 6'h0D;
    localparam logic [5:0] OpBeqz  = 6'h0E;
    localparam logic [5:0] OpHlt   = 6'h3F;

    logic [31:0]     Mem [0:MEM_DEPTH-1];
    logic [XLEN-1:0] Reg [0:31];

    logic [XLEN-1:0] pc;
    logic [31:0]     if_id_ir;
    logic [XLEN-1:0] if_id_npc;
    logic [31:0]     id_ex_ir;
    logic [XLEN-1:0] id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
    logic [31:0]     ex_mem_ir;
    logic [XLEN-1:0] ex_mem_alu, ex_mem_b;
    logic            ex_mem_taken;
    logic [31:0]     mem_wb_ir;
    logic [XLEN-1:0] mem_wb_alu, mem_wb_lmd;
    logic            halted;
    logic            pow_busy;
    logic [XLEN-1:0] pow_acc, pow_base, pow_exp;

    logic [5:0]      ex_op, mem_op, wb_op;
    logic [XLEN-1:0] id_a, id_b, id_imm, ex_alu, mem_rdata;
    logic [31:0]     if_ir;
    logic            ex_taken, pow_hold, freeze, flush;
    logic [XLEN-1:0] pow_step_acc, pow_step_base, pow_step_exp;
    logic            wb_we;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            unused_wb_fields;

    assign unused_wb_fields = ^{mem_wb_ir[25:21], mem_wb_ir[10:0]};

    assign if_ir     = Mem[pc[AW-1:0]];
    assign id_a      = Reg[if_id_ir[25:21]];
    assign id_b      = Reg[if_id_ir[20:16]];
    assign id_imm    = {{(XLEN-16){if_id_ir[15]}}, if_id_ir[15:0]};
    assign ex_op     = id_ex_ir[31:26];
    assign mem_op    = ex_mem_ir[31:26];
    assign wb_op     = mem_wb_ir[31:26];
    assign mem_rdata = Mem[ex_mem_alu[AW-1:0]];

    // Once HLT sits in MEM/WB nothing younger may commit, so the whole pipe stops.
    assign freeze = halted || (wb_op == OpHlt);
    assign flush  = ex_mem_taken && !freeze;

    // LSB-first square-and-multiply; the last step's product leaves EX directly.
    assign pow_step_acc  = pow_exp[0] ? pow_acc * pow_base : pow_acc;
    assign pow_step_base = pow_base * pow_base;
    assign pow_step_exp  = pow_exp >> 1;
    assign pow_hold      = (ex_op == OpPow) &&
                           (pow_busy ? (pow_step_exp != '0) : (id_ex_b != '0));

    always_comb begin
        ex_alu   = '0;
        ex_taken = 1'b0;
        unique case (ex_op)
            OpAdd:   ex_alu = id_ex_a + id_ex_b;
            OpSub:   ex_alu = id_ex_a - id_ex_b;
            OpAnd:   ex_alu = id_ex_a & id_ex_b;
            OpOr:    ex_alu = id_ex_a | id_ex_b;
            OpSlt:   ex_alu = {{(XLEN-1){1'b0}}, $signed(id_ex_a) < $signed(id_ex_b)};
            OpMul:   ex_alu = id_ex_a * id_ex_b;
            OpPow:   ex_alu = pow_busy ? pow_step_acc : {{(XLEN-1){1'b0}}, 1'b1};
            OpAddi:  ex_alu = id_ex_a + id_ex_imm;
            OpSubi:  ex_alu = id_ex_a - id_ex_imm;
            OpSlti:  ex_alu = {{(XLEN-1){1'b0}}, $signed(id_ex_a) < $signed(id_ex_imm)};
            OpLw,
            OpSw:    ex_alu = id_ex_a + id_ex_imm;
            OpBneqz: begin
                ex_alu   = id_ex_npc + id_ex_imm;
                ex_taken = (id_ex_a != '0);
            end
            OpBeqz:  begin
                ex_alu   = id_ex_npc + id_ex_imm;
                ex_taken = (id_ex_a == '0);
            end
            default: ex_alu = '0;
        endcase
    end

    always_comb begin
        wb_we   = 1'b0;
        wb_addr = '0;
        wb_data = mem_wb_alu;
        unique case (wb_op)
            OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul, OpPow: begin
                wb_we   = 1'b1;
                wb_addr = mem_wb_ir[15:11];
            end
            OpAddi, OpSubi, OpSlti: begin
                wb_we   = 1'b1;
                wb_addr = mem_wb_ir[20:16];
            end
            OpLw: begin
                wb_we   = 1'b1;
                wb_addr = mem_wb_ir[20:16];
                wb_data = mem_wb_lmd;
            end
            default: wb_we = 1'b0;
        endcase
        wb_we = wb_we && !freeze && (wb_addr != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Reg[0] <= '0;
        end else if (wb_we) begin
            Reg[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_op == OpSw && !freeze) begin
            Mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= '0;
            if_id_ir     <= '0;
            if_id_npc    <= '0;
            id_ex_ir     <= '0;
            id_ex_npc    <= '0;
            id_ex_a      <= '0;
            id_ex_b      <= '0;
            id_ex_imm    <= '0;
            ex_mem_ir    <= '0;
            ex_mem_alu   <= '0;
            ex_mem_b     <= '0;
            ex_mem_taken <= 1'b0;
            mem_wb_ir    <= '0;
            mem_wb_alu   <= '0;
            mem_wb_lmd   <= '0;
            halted       <= 1'b0;
            pow_busy     <= 1'b0;
            pow_acc      <= '0;
            pow_base     <= '0;
            pow_exp      <= '0;
        end else if (freeze) begin
            halted <= 1'b1;
        end else begin
            mem_wb_ir  <= ex_mem_ir;
            mem_wb_alu <= ex_mem_alu;
            mem_wb_lmd <= mem_rdata;
            if (flush) begin
                // Taken branch in MEM: redirect and kill the three younger slots.
                pc           <= ex_mem_alu;
                if_id_ir     <= '0;
                if_id_npc    <= '0;
                id_ex_ir     <= '0;
                id_ex_npc    <= '0;
                id_ex_a      <= '0;
                id_ex_b      <= '0;
                id_ex_imm    <= '0;
                ex_mem_ir    <= '0;
                ex_mem_alu   <= '0;
                ex_mem_b     <= '0;
                ex_mem_taken <= 1'b0;
                pow_busy     <= 1'b0;
            end else if (pow_hold) begin
                ex_mem_ir    <= '0;
                ex_mem_alu   <= '0;
                ex_mem_b     <= '0;
                ex_mem_taken <= 1'b0;
                pow_busy     <= 1'b1;
                pow_acc      <= pow_busy ? pow_step_acc : {{(XLEN-1){1'b0}}, 1'b1};
                pow_base     <= pow_busy ? pow_step_base : id_ex_a;
                pow_exp      <= pow_busy ? pow_step_exp : id_ex_b;
            end else begin
                pc           <= pc + {{(XLEN-1){1'b0}}, 1'b1};
                if_id_ir     <= if_ir;
                if_id_npc    <= pc + {{(XLEN-1){1'b0}}, 1'b1};
                id_ex_ir     <= if_id_ir;
                id_ex_npc    <= if_id_npc;
                id_ex_a      <= id_a;
                id_ex_b      <= id_b;
                id_ex_imm    <= id_imm;
                ex_mem_ir    <= id_ex_ir;
                ex_mem_alu   <= ex_alu;
                ex_mem_b     <= id_ex_b;
                ex_mem_taken <= ex_taken;
                pow_busy     <= 1'b0;
            end
        end
    end

    assign pc_out         = pc;
    assign alu_result     = ex_mem_alu;
    assign halted_out     = halted;
    assign debug_operand1 = id_ex_a;
    assign debug_operand2 = id_ex_b;

endmodule

// File: tb/tb_pipe_mips20.sv
// Directed program bench for pipe_mips20: preloads Mem, runs to HLT, checks Reg/Mem/outputs.
module tb_pipe_mips20;
    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out, alu_result, debug_operand1, debug_operand2;
    logic        halted_out;

    int checks   = 0;
    int failures = 0;
    int cyc;

    localparam logic [5:0] OpAdd   = 6'h00;
    localparam logic [5:0] OpSub   = 6'h01;
    localparam logic [5:0] OpAnd   = 6'h02;
    localparam logic [5:0] OpOr    = 6'h03;
    localparam logic [5:0] OpSlt   = 6'h04;
    localparam logic [5:0] OpMul   = 6'h05;
    localparam logic [5:0] OpPow   = 6'h10;
    localparam logic [5:0] OpLw    = 6'h08;
    localparam logic [5:0] OpSw    = 6'h09;
    localparam logic [5:0] OpAddi  = 6'h0A;
    localparam logic [5:0] OpSubi  = 6'h0B;
    localparam logic [5:0] OpSlti  = 6'h0C;
    localparam logic [5:0] OpBneqz = 6'h0D;
    localparam logic [5:0] OpBeqz  = 6'h0E;
    localparam logic [31:0] Hlt    = 32'hFC00_0000;

    pipe_mips20 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_out         (pc_out),
        .alu_result     (alu_result),
        .halted_out     (halted_out),
        .debug_operand1 (debug_operand1),
        .debug_operand2 (debug_operand2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [5:0] op, input int rd, input int rs,
                                       input int rt);
        logic [4:0] d, s, t;
        d = rd[4:0];
        s = rs[4:0];
        t = rt[4:0];
        return {op, s, t, d, 11'b0};
    endfunction

    function automatic logic [31:0] ri(input logic [5:0] op, input int rt, input int rs,
                                       input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0];
        t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assert reset on a falling edge and clear Mem so each program starts clean.
    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'h0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_halt(input int max_cyc, output int n);
        n = 0;
        while (halted_out !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic load_prog1();
        dut.Mem[0]  = ri(OpAddi, 1, 0, 16'd2);
        dut.Mem[4]  = ri(OpAddi, 2, 0, 16'd5);
        dut.Mem[8]  = 32'h4022_1800;
        dut.Mem[12] = Hlt;
        dut.Mem[13] = ri(OpAddi, 8, 0, 16'd9);
        dut.Mem[14] = ri(OpSw, 1, 0, 16'd50);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 1; i < 32; i++) dut.Reg[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_alu", alu_result, 32'h0);
        chk("rst_halt", {31'b0, halted_out}, 32'h0);
        chk("rst_op1", debug_operand1, 32'h0);
        chk("rst_op2", debug_operand2, 32'h0);

        // Program 1: POW 2^5 with stall, HLT, and writers parked behind HLT
        enter_reset();
        load_prog1();
        leave_reset();
        run_halt(200, cyc);
        chk("p1_halt", {31'b0, halted_out}, 32'h1);
        chk("p1_cycles", cyc, 32'd20);
        chk("p1_r1", dut.Reg[1], 32'd2);
        chk("p1_r2", dut.Reg[2], 32'd5);
        chk("p1_r3", dut.Reg[3], 32'd32);
        chk("p1_pc", pc_out, 32'd16);

        // ALU mix with R1=7, R2=3
        enter_reset();
        dut.Mem[0]  = ri(OpAddi, 1, 0, 16'd7);
        dut.Mem[1]  = ri(OpAddi, 2, 0, 16'd3);
        dut.Mem[5]  = rr(OpAdd, 10, 1, 2);
        dut.Mem[6]  = rr(OpSub, 11, 1, 2);
        dut.Mem[7]  = rr(OpAnd, 12, 1, 2);
        dut.Mem[8]  = rr(OpOr, 13, 1, 2);
        dut.Mem[9]  = rr(OpSlt, 14, 1, 2);
        dut.Mem[10] = rr(OpMul, 15, 1, 2);
        dut.Mem[11] = ri(OpSubi, 16, 1, 16'd1);
        dut.Mem[12] = ri(OpSlti, 17, 1, 16'd8);
        dut.Mem[13] = ri(OpAddi, 20, 0, 16'hFFFF);
        dut.Mem[14] = Hlt;
        dut.Reg[14] = 32'h55;
        leave_reset();
        run_halt(200, cyc);
        chk("alu_halt", {31'b0, halted_out}, 32'h1);
        chk("alu_cycles", cyc, 32'd19);
        chk("alu_add", dut.Reg[10], 32'd10);
        chk("alu_sub", dut.Reg[11], 32'd4);
        chk("alu_and", dut.Reg[12], 32'd3);
        chk("alu_or", dut.Reg[13], 32'd7);
        chk("alu_slt", dut.Reg[14], 32'd0);
        chk("alu_mul", dut.Reg[15], 32'd21);
        chk("alu_subi", dut.Reg[16], 32'd6);
        chk("alu_slti", dut.Reg[17], 32'd1);
        chk("alu_addi_neg", dut.Reg[20], 32'hFFFF_FFFF);

        // POW edge cases, each followed by an ADD
        enter_reset();
        dut.Mem[0]  = ri(OpAddi, 1, 0, 16'd3);
        dut.Mem[1]  = ri(OpAddi, 3, 0, 16'd4);
        dut.Mem[2]  = ri(OpAddi, 4, 0, 16'd32);
        dut.Mem[3]  = ri(OpAddi, 5, 0, 16'd2);
        dut.Mem[7]  = rr(OpPow, 10, 1, 0);
        dut.Mem[8]  = rr(OpAdd, 20, 1, 3);
        dut.Mem[9]  = rr(OpPow, 11, 0, 3);
        dut.Mem[10] = rr(OpAdd, 21, 3, 4);
        dut.Mem[11] = rr(OpPow, 12, 5, 4);
        dut.Mem[12] = rr(OpAdd, 22, 5, 1);
        dut.Mem[13] = rr(OpPow, 13, 1, 3);
        dut.Mem[14] = rr(OpAdd, 23, 4, 5);
        dut.Mem[15] = Hlt;
        dut.Reg[11] = 32'hDEAD;
        dut.Reg[12] = 32'hBEEF;
        leave_reset();
        run_halt(300, cyc);
        chk("pow_halt", {31'b0, halted_out}, 32'h1);
        chk("pow_cycles", cyc, 32'd32);
        chk("pow_3_0", dut.Reg[10], 32'd1);
        chk("pow_0_4", dut.Reg[11], 32'd0);
        chk("pow_2_32", dut.Reg[12], 32'd0);
        chk("pow_3_4", dut.Reg[13], 32'd81);
        chk("pow_add_a", dut.Reg[20], 32'd7);
        chk("pow_add_b", dut.Reg[21], 32'd36);
        chk("pow_add_c", dut.Reg[22], 32'd5);
        chk("pow_add_d", dut.Reg[23], 32'd34);

        // SW/LW, including a 0xFFFF offset
        enter_reset();
        dut.Mem[0]  = ri(OpAddi, 1, 0, 16'h1234);
        dut.Mem[1]  = ri(OpAddi, 2, 0, 16'd100);
        dut.Mem[2]  = ri(OpAddi, 3, 0, 16'd201);
        dut.Mem[6]  = ri(OpSw, 1, 2, 16'h0000);
        dut.Mem[7]  = ri(OpSw, 1, 3, 16'hFFFF);
        dut.Mem[8]  = ri(OpLw, 5, 2, 16'h0000);
        dut.Mem[9]  = ri(OpLw, 6, 3, 16'hFFFF);
        dut.Mem[13] = Hlt;
        dut.Reg[5]  = 32'h0;
        dut.Reg[6]  = 32'h0;
        leave_reset();
        run_halt(200, cyc);
        chk("mem_halt", {31'b0, halted_out}, 32'h1);
        chk("mem_sw100", dut.Mem[100], 32'h1234);
        chk("mem_sw200", dut.Mem[200], 32'h1234);
        chk("mem_sw201", dut.Mem[201], 32'h0);
        chk("mem_lw_r5", dut.Reg[5], 32'h1234);
        chk("mem_lw_r6", dut.Reg[6], 32'h1234);

        // Countdown loop; ADDI R9 slots must always be squashed
        enter_reset();
        dut.Mem[0]  = ri(OpAddi, 1, 0, 16'd3);
        dut.Mem[4]  = ri(OpSubi, 1, 1, 16'd1);
        dut.Mem[5]  = ri(OpAddi, 7, 7, 16'd1);
        dut.Mem[8]  = ri(OpBneqz, 0, 1, 16'hFFFB);
        dut.Mem[9]  = ri(OpBeqz, 0, 0, 16'd3);
        dut.Mem[10] = ri(OpAddi, 9, 0, 16'd1);
        dut.Mem[11] = ri(OpAddi, 9, 0, 16'd1);
        dut.Mem[12] = ri(OpAddi, 9, 0, 16'd1);
        dut.Mem[13] = Hlt;
        dut.Reg[7]  = 32'h0;
        dut.Reg[9]  = 32'h0;
        leave_reset();
        run_halt(400, cyc);
        chk("loop_halt", {31'b0, halted_out}, 32'h1);
        chk("loop_r1", dut.Reg[1], 32'd0);
        chk("loop_iter", dut.Reg[7], 32'd3);
        chk("loop_r9", dut.Reg[9], 32'd0);
        chk("loop_pc", pc_out, 32'd17);

        // Reset asserted in the middle of the POW hold
        enter_reset();
        load_prog1();
        dut.Reg[3] = 32'h0;
        dut.Reg[8] = 32'h0;
        leave_reset();
        repeat (12) @(negedge clk);
        chk("hold_pc", pc_out, 32'd10);
        chk("hold_op1", debug_operand1, 32'd2);
        chk("hold_op2", debug_operand2, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_op1", debug_operand1, 32'h0);
        chk("arst_op2", debug_operand2, 32'h0);
        chk("arst_alu", alu_result, 32'h0);
        chk("arst_halt", {31'b0, halted_out}, 32'h0);
        chk("arst_r3", dut.Reg[3], 32'h0);
        leave_reset();
        run_halt(200, cyc);
        chk("rerun_halt", {31'b0, halted_out}, 32'h1);
        chk("rerun_cycles", cyc, 32'd20);
        chk("rerun_r3", dut.Reg[3], 32'd32);
        repeat (10) @(negedge clk);
        chk("post_halt", {31'b0, halted_out}, 32'h1);
        chk("post_pc", pc_out, 32'd16);
        chk("post_r8", dut.Reg[8], 32'h0);
        chk("post_mem50", dut.Mem[50], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
